// File: rtl/arb_pkg.sv
// Types and constants shared by the requester, the arbiter and their benches.
package arb_pkg;

  localparam int CH_NUM = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BUSY,
    REL
  } req_state_t;

endpackage

// File: rtl/arb_requester_if.sv
// Producer/arbiter-facing bundle of the requester; master is the requester side.
interface arb_requester_if
  import arb_pkg::*;
#(
  parameter int LEN_W = 4
) ();

  logic [CH_NUM-1:0]            job_valid;
  logic [CH_NUM-1:0][LEN_W-1:0] job_len;
  logic [CH_NUM-1:0]            job_ready;
  logic [CH_NUM-1:0]            request;
  logic [CH_NUM-1:0]            grant;
  logic [CH_NUM-1:0]            active;
  logic [CH_NUM-1:0]            done;
  logic [CH_NUM-1:0]            starve;
  logic [CH_NUM-1:0]            grant_err;

  modport master (
    input  job_valid, job_len, grant,
    output job_ready, request, active, done, starve, grant_err
  );

  modport slave (
    output job_valid, job_len, grant,
    input  job_ready, request, active, done, starve, grant_err
  );

endinterface

// File: rtl/arb_req_chan.sv
// One requester channel: job FIFO, request/grant FSM, burst and starvation counters.
//   state | meaning
//   IDLE  | no pending job, request low
//   REQ   | job pending, request high, waiting for grant
//   BUSY  | granted, owns the resource, counting down the burst
//   REL   | one-cycle release gap so the arbiter sees request low
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LEN_W      = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid_i,
  input  logic [LEN_W-1:0] job_len_i,
  output logic             job_ready_o,
  input  logic             grant_i,
  output logic             request_o,
  output logic             active_o,
  output logic             done_o,
  output logic             starve_o,
  output logic             grant_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(STARVE_LIM + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(STARVE_LIM);

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             full, empty, push, pop, granted, done;
  logic [LEN_W-1:0] head_len;

  req_state_t       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             starve_q, starve_d, grant_err_q;

  // Only a clean 1 is a grant; X/Z from the arbiter must not start a burst.
  assign granted  = (grant_i === 1'b1);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = job_valid_i && !full;
  assign pop      = done;
  assign head_len = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= job_len_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      starve_q    <= 1'b0;
      grant_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
      grant_err_q <= (state_q == IDLE) && granted;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    done     = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) state_d = REQ;
      REQ: begin
        if (granted) begin
          state_d  = BUSY;
          cnt_d    = (head_len == '0) ? LEN_W'(1) : head_len;
          wait_d   = '0;
          starve_d = 1'b0;
        end else if (wait_q != WAIT_LIM) begin
          wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_LIM) starve_d = 1'b1;
        end
      end
      BUSY: begin
        // Losing the grant mid-burst keeps the job queued; it restarts from full length.
        if (!granted) begin
          state_d = REQ;
        end else if (cnt_q == LEN_W'(1)) begin
          done    = 1'b1;
          state_d = REL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      REL: state_d = empty ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  assign job_ready_o = !full;
  assign request_o   = (state_q == REQ) || (state_q == BUSY);
  assign active_o    = (state_q == BUSY);
  assign done_o      = done;
  assign starve_o    = starve_q;
  assign grant_err_o = grant_err_q;

endmodule

// File: rtl/arb_requester.sv
// Two-channel initiator for the fixed-priority request/grant arbiter; one channel per bit.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int LEN_W      = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic           clk,
  input  logic           rst,
  arb_requester_if.master bus
);

  logic [CH_NUM-1:0] job_ready, request, active, done, starve, grant_err;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
    arb_req_chan #(
      .DEPTH      (DEPTH),
      .LEN_W      (LEN_W),
      .STARVE_LIM (STARVE_LIM)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .job_valid_i (bus.job_valid[g]),
      .job_len_i   (bus.job_len[g]),
      .job_ready_o (job_ready[g]),
      .grant_i     (bus.grant[g]),
      .request_o   (request[g]),
      .active_o    (active[g]),
      .done_o      (done[g]),
      .starve_o    (starve[g]),
      .grant_err_o (grant_err[g])
    );
  end

  assign bus.job_ready = job_ready;
  assign bus.request   = request;
  assign bus.active    = active;
  assign bus.done      = done;
  assign bus.starve    = starve;
  assign bus.grant_err = grant_err;

endmodule

// File: tb/tb_arb_requester.sv
// Requester against a registered fixed-priority arbiter model, with a grant override.
module tb_arb_requester;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  arb_requester_if #(.LEN_W(4)) bus ();

  arb_requester #(.DEPTH(4), .LEN_W(4), .STARVE_LIM(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Arbiter model: bit 1 wins, holder keeps the grant while it still requests.
  logic [1:0] arb_q;
  logic       ovr_en  = 1'b0;
  logic [1:0] ovr_val = 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         arb_q <= 2'b00;
    else if ((arb_q & bus.request) != 2'b00) arb_q <= arb_q;
    else if (bus.request[1])          arb_q <= 2'b10;
    else if (bus.request[0])          arb_q <= 2'b01;
    else                              arb_q <= 2'b00;
  end

  assign bus.grant = ovr_en ? ovr_val : arb_q;

  int vectors = 0;
  int miscompares = 0;
  int q0[$];
  int q1[$];
  int run_len[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input logic [3:0] l);
    return (l == 4'd0) ? 1 : int'(l);
  endfunction

  // Scoreboard: each done must close a run of active cycles of the queued length.
  task automatic mon_chan(input int ch);
    int n, exp_len;
    if (bus.active[ch]) run_len[ch]++;
    else                run_len[ch] = 0;
    if (bus.done[ch]) begin
      n = (ch == 0) ? q0.size() : q1.size();
      check($sformatf("done%0d_has_job", ch), (n != 0), 1);
      check($sformatf("done%0d_active", ch), bus.active[ch], 1);
      if (n != 0) begin
        exp_len = (ch == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("done%0d_len", ch), run_len[ch], exp_len);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      run_len[0] = 0;
      run_len[1] = 0;
    end else begin
      mon_chan(0);
      mon_chan(1);
    end
  end

  task automatic drive(input logic [1:0] v, input logic [3:0] l0, input logic [3:0] l1,
                       input logic [1:0] acc);
    bus.job_valid  = v;
    bus.job_len[0] = l0;
    bus.job_len[1] = l1;
    if (acc[0]) q0.push_back(eff_len(l0));
    if (acc[1]) q1.push_back(eff_len(l1));
    @(posedge clk);
    #1 bus.job_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic wait_done(input int ch, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done[ch]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("wait_done%0d", ch), got, 1);
  endtask

  task automatic wait_active(input int ch, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.active[ch]) begin
        got = 1'b1;
        break;
      end
    end
    check($sformatf("wait_active%0d", ch), got, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.request == 2'b00 && bus.active == 2'b00 && q0.size() == 0 && q1.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    check("wait_idle", got, 1);
    check("idle_starve", bus.starve, 2'b00);
    check("idle_grant_err", bus.grant_err, 2'b00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.job_valid = 2'b00;
    bus.job_len   = '0;

    // Reset state
    #1;
    check("rst_request", bus.request, 2'b00);
    check("rst_active", bus.active, 2'b00);
    check("rst_job_ready", bus.job_ready, 2'b11);
    check("rst_starve", bus.starve, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single ch0 job, len 3
    drive(2'b01, 4'd3, 4'd0, 2'b01);
    check("t2_req_n0", bus.request, 2'b00);
    @(negedge clk);
    check("t2_req_n1", bus.request, 2'b01);
    check("t2_gnt_n1", bus.grant, 2'b00);
    @(negedge clk);
    check("t2_gnt_n2", bus.grant, 2'b01);
    check("t2_act_n2", bus.active, 2'b00);
    @(negedge clk);
    check("t2_act_n3", bus.active, 2'b01);
    @(negedge clk);
    check("t2_done_n4", bus.done, 2'b00);
    @(negedge clk);
    check("t2_done_n5", bus.done, 2'b01);
    @(negedge clk);
    check("t2_req_rel", bus.request, 2'b00);
    check("t2_act_rel", bus.active, 2'b00);
    @(negedge clk);
    check("t2_gnt_idle", bus.grant, 2'b00);
    wait_idle(20);

    // Both channels len 2 at once: ch1 first
    drive(2'b11, 4'd2, 4'd2, 2'b11);
    @(negedge clk);
    check("t3_req_both", bus.request, 2'b11);
    @(negedge clk);
    check("t3_gnt_ch1", bus.grant, 2'b10);
    wait_done(1, 20);
    @(negedge clk);
    check("t3_req_ch1_rel", bus.request, 2'b01);
    check("t3_gnt_lag", bus.grant, 2'b10);
    @(negedge clk);
    check("t3_gnt_ch0", bus.grant, 2'b01);
    wait_idle(30);

    // ch1 hogs with long bursts; ch0 starves then recovers
    drive(2'b11, 4'd2, 4'd15, 2'b11);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.job_valid = 2'b10;
        bus.job_len[1] = 4'd15;
        q1.push_back(15);
      end else begin
        bus.job_valid = 2'b00;
      end
      if (bus.starve[0]) break;
      if (bus.request[0]) n++;
    end
    bus.job_valid = 2'b00;
    check("t4_starve_set", bus.starve[0], 1'b1);
    check("t4_req_cycles", n, 16);
    check("t4_ch0_not_active", bus.active[0], 1'b0);
    wait_active(0, 40);
    check("t4_starve_clr", bus.starve[0], 1'b0);
    wait_idle(80);

    // Grant lost on 3rd BUSY cycle of a len 5 job
    drive(2'b01, 4'd5, 4'd0, 2'b01);
    wait_active(0, 20);
    @(negedge clk);
    @(negedge clk);
    ovr_en = 1'b1;
    ovr_val = 2'b00;
    check("t5_act_busy3", bus.active, 2'b01);
    @(negedge clk);
    ovr_en = 1'b0;
    check("t5_req_after_loss", bus.request, 2'b01);
    check("t5_act_after_loss", bus.active, 2'b00);
    check("t5_done_after_loss", bus.done, 2'b00);
    wait_idle(30);
    ovr_en = 1'b1;
    ovr_val = 2'b01;
    @(negedge clk);
    ovr_en = 1'b0;
    check("t5_grant_err", bus.grant_err, 2'b01);
    @(negedge clk);
    check("t5_grant_err_pulse", bus.grant_err, 2'b00);

    // Fill ch0 with grant withheld, drop a push, then push+pop together
    ovr_en = 1'b1;
    ovr_val = 2'b00;
    drive(2'b01, 4'd0, 4'd0, 2'b01);
    drive(2'b01, 4'd1, 4'd0, 2'b01);
    drive(2'b01, 4'd2, 4'd0, 2'b01);
    drive(2'b01, 4'd3, 4'd0, 2'b01);
    check("t6_full", bus.job_ready, 2'b10);
    drive(2'b01, 4'd7, 4'd0, 2'b00);
    check("t6_still_full", bus.job_ready, 2'b10);
    ovr_en = 1'b0;
    wait_done(0, 20);
    @(negedge clk);
    check("t6_ready_after_pop", bus.job_ready, 2'b11);
    wait_done(0, 20);
    bus.job_valid = 2'b01;
    bus.job_len[0] = 4'd4;
    q0.push_back(4);
    @(posedge clk);
    #1 bus.job_valid = 2'b00;
    @(negedge clk);
    check("t6_pushpop_count3", bus.job_ready, 2'b11);
    drive(2'b01, 4'd5, 4'd0, 2'b01);
    check("t6_full_again", bus.job_ready, 2'b10);
    wait_idle(80);

    // Reset in the middle of traffic
    drive(2'b11, 4'd6, 4'd6, 2'b11);
    drive(2'b11, 4'd6, 4'd6, 2'b11);
    wait_active(1, 20);
    #2 rst = 1'b0;
    #1;
    check("t1_request", bus.request, 2'b00);
    check("t1_active", bus.active, 2'b00);
    check("t1_done", bus.done, 2'b00);
    check("t1_starve", bus.starve, 2'b00);
    check("t1_grant_err", bus.grant_err, 2'b00);
    check("t1_job_ready", bus.job_ready, 2'b11);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_fifo_empty_req", bus.request, 2'b00);
    check("t1_fifo_empty_rdy", bus.job_ready, 2'b11);

    check("sb_q0_empty", q0.size(), 0);
    check("sb_q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
